// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU input sequencer and its helpers.
package tpu_pkg;

    // Default operand width, matching the core input FIFO width.
    localparam int unsigned DATA_W_DEF = 32;

    // Depth of each core input FIFO (row0 / row1).
    localparam int unsigned CORE_FIFO_DEPTH = 2;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_GAP  = 3'd4
    } seq_state_e;

    // Bits needed to hold any value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tpu_run_timer.sv
// Clearable up-counter with a terminal-count compare; shared by RUN timeout and GAP hold.
module tpu_run_timer #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_tc,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart from zero on clear, otherwise advance by one.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clr) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count reached in the current cycle.
    assign o_tc_c = (cnt_q == i_tc);

endmodule

// File: rtl/tpu_input_sequencer.sv
// Feeds operand words alternately into the 2x2 systolic core's row FIFOs,
// then holds the core's start high until done, timeout or abort.
module tpu_input_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned VECS_PER_JOB   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned JOBCNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_abort,
    input  logic                i_s_valid,
    input  logic [DATA_W-1:0]   i_s_data,
    output logic                o_s_ready,
    input  logic [1:0]          i_full,
    input  logic                i_done,
    output logic [DATA_W-1:0]   o_in1,
    output logic                o_in1_en,
    output logic [DATA_W-1:0]   o_in2,
    output logic                o_in2_en,
    output logic                o_start,
    output logic                o_busy,
    output logic                o_job_done,
    output logic                o_timeout,
    output logic [JOBCNT_W-1:0] o_job_cnt
);

    localparam int unsigned WORDS   = 2 * VECS_PER_JOB;
    localparam int unsigned WIDX_W  = cnt_width(WORDS - 1);
    localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);
    localparam logic [TMR_W-1:0]  TC_RUN    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TC_GAP    = TMR_W'(GAP_CYCLES - 1);

    seq_state_e          state_q,    state_d;
    logic [WIDX_W-1:0]   widx_q,     widx_d;
    logic [DATA_W-1:0]   in1_q,      in1_d;
    logic                in1_en_q,   in1_en_d;
    logic [DATA_W-1:0]   in2_q,      in2_d;
    logic                in2_en_q,   in2_en_d;
    logic                start_q,    start_d;
    logic                busy_q,     busy_d;
    logic                job_done_q, job_done_d;
    logic                timeout_q,  timeout_d;
    logic [JOBCNT_W-1:0] job_cnt_q,  job_cnt_d;

    logic                tgt_row_c;
    logic                s_ready_c;
    logic                handshake_c;
    logic                timer_clr_c;
    logic [TMR_W-1:0]    timer_tc_val_c;
    logic                timer_tc_c;

    // Shared timer: RUN timeout and GAP hold never overlap.
    tpu_run_timer #(
        .CNT_W (TMR_W)
    ) u_run_timer (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (timer_clr_c),
        .i_tc   (timer_tc_val_c),
        .o_tc_c (timer_tc_c)
    );

    // Stream ready: only while loading, the target FIFO has room, and no abort.
    // Rows alternate, so the only pending write targets the other FIFO and the
    // full flag of the target row is current.
    always_comb begin
        tgt_row_c   = widx_q[0];
        s_ready_c   = (state_q == ST_LOAD) && !i_full[tgt_row_c] && !i_abort;
        handshake_c = i_s_valid && s_ready_c;
    end

    assign o_s_ready = s_ready_c;

    // Next-state and registered-output decisions.
    always_comb begin
        state_d        = state_q;
        widx_d         = widx_q;
        in1_d          = in1_q;
        in1_en_d       = 1'b0;
        in2_d          = in2_q;
        in2_en_d       = 1'b0;
        start_d        = 1'b0;
        job_done_d     = 1'b0;
        timeout_d      = 1'b0;
        job_cnt_d      = job_cnt_q;
        timer_tc_val_c = (state_q == ST_RUN) ? TC_RUN : TC_GAP;

        if (i_abort) begin
            state_d = ST_GAP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_en) begin
                        state_d = ST_LOAD;
                        widx_d  = '0;
                    end
                end
                ST_LOAD: begin
                    if (handshake_c) begin
                        if (tgt_row_c == 1'b0) begin
                            in1_d    = i_s_data;
                            in1_en_d = 1'b1;
                        end else begin
                            in2_d    = i_s_data;
                            in2_en_d = 1'b1;
                        end
                        widx_d = widx_q + WIDX_W'(1);
                        if (widx_q == WIDX_LAST) begin
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    state_d = ST_RUN;
                    start_d = 1'b1;
                end
                ST_RUN: begin
                    start_d = 1'b1;
                    if (i_done) begin
                        job_done_d = 1'b1;
                        job_cnt_d  = job_cnt_q + JOBCNT_W'(1);
                        start_d    = 1'b0;
                        state_d    = ST_GAP;
                    end else if (timer_tc_c) begin
                        timeout_d = 1'b1;
                        start_d   = 1'b0;
                        state_d   = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_tc_c) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);

        // Timer runs only while staying in RUN or GAP; any entry restarts it at zero.
        timer_clr_c = i_abort || (state_d != state_q) ||
                      !((state_q == ST_RUN) || (state_q == ST_GAP));
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            widx_q     <= '0;
            in1_q      <= '0;
            in1_en_q   <= 1'b0;
            in2_q      <= '0;
            in2_en_q   <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            job_done_q <= 1'b0;
            timeout_q  <= 1'b0;
            job_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            in1_q      <= in1_d;
            in1_en_q   <= in1_en_d;
            in2_q      <= in2_d;
            in2_en_q   <= in2_en_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            job_done_q <= job_done_d;
            timeout_q  <= timeout_d;
            job_cnt_q  <= job_cnt_d;
        end
    end

    assign o_in1      = in1_q;
    assign o_in1_en   = in1_en_q;
    assign o_in2      = in2_q;
    assign o_in2_en   = in2_en_q;
    assign o_start    = start_q;
    assign o_busy     = busy_q;
    assign o_job_done = job_done_q;
    assign o_timeout  = timeout_q;
    assign o_job_cnt  = job_cnt_q;

endmodule

// File: tb/tb_tpu_input_sequencer.sv
// Self-checking bench for tpu_input_sequencer: directed scenarios plus randomized jobs
// checked against a job-level model (word routing, start duration, pulses, counter).
module tb_tpu_input_sequencer;
    import tpu_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 4;   // narrow counter so the wrap is reachable quickly
    localparam int unsigned TO    = 16;
    localparam int unsigned GAPC  = 1;
    localparam int unsigned WORDS = 4;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic          i_abort;
    logic          i_s_valid;
    logic [DW-1:0] i_s_data;
    logic          o_s_ready;
    logic [1:0]    i_full;
    logic          i_done;
    logic [DW-1:0] o_in1;
    logic          o_in1_en;
    logic [DW-1:0] o_in2;
    logic          o_in2_en;
    logic          o_start;
    logic          o_busy;
    logic          o_job_done;
    logic          o_timeout;
    logic [CW-1:0] o_job_cnt;

    always #5 i_clk = ~i_clk;

    tpu_input_sequencer #(
        .DATA_W         (DW),
        .VECS_PER_JOB   (2),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAPC),
        .JOBCNT_W       (CW)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_abort    (i_abort),
        .i_s_valid  (i_s_valid),
        .i_s_data   (i_s_data),
        .o_s_ready  (o_s_ready),
        .i_full     (i_full),
        .i_done     (i_done),
        .o_in1      (o_in1),
        .o_in1_en   (o_in1_en),
        .o_in2      (o_in2),
        .o_in2_en   (o_in2_en),
        .o_start    (o_start),
        .o_busy     (o_busy),
        .o_job_done (o_job_done),
        .o_timeout  (o_timeout),
        .o_job_cnt  (o_job_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q1[$];
    logic [DW-1:0] q2[$];
    logic [DW-1:0] w[WORDS];
    int occ0, occ1;
    int n_start, n_jd, n_to, n_gap;
    int acc;
    int exp_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; collect strobes and pulses seen after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        if (o_in1_en === 1'b1) begin q1.push_back(o_in1); occ0++; end
        if (o_in2_en === 1'b1) begin q2.push_back(o_in2); occ1++; end
        if (o_start === 1'b1) n_start++;
        if (o_job_done === 1'b1) n_jd++;
        if (o_timeout === 1'b1) n_to++;
        if (o_busy === 1'b1 && o_start === 1'b0 && n_start > 0) n_gap++;
    endtask

    task automatic new_job();
        q1.delete();
        q2.delete();
        n_start = 0; n_jd = 0; n_to = 0; n_gap = 0; acc = 0;
        for (int i = 0; i < int'(WORDS); i++) w[i] = $urandom;
        i_en = 1'b1;
        step();
        i_en = 1'b0;
        chk("busy_in_load", 64'(o_busy), 64'd1);
    endtask

    // Offer words until 'upto' have been accepted; ready is predicted from the row parity.
    task automatic feed(input int upto, input bit rnd, output int cyc);
        cyc = 0;
        while (acc < upto && cyc < 200) begin
            logic vld;
            logic exp_rdy;
            vld       = !rnd || ($urandom_range(0, 3) != 0);
            i_full[0] = (rnd && ($urandom_range(0, 4) == 0)) || (occ0 >= int'(CORE_FIFO_DEPTH));
            i_full[1] = (rnd && ($urandom_range(0, 4) == 0)) || (occ1 >= int'(CORE_FIFO_DEPTH));
            i_s_valid = vld;
            i_s_data  = w[acc];
            exp_rdy   = !i_full[acc % 2];
            #1;
            chk("s_ready", 64'(o_s_ready), 64'(exp_rdy));
            if (vld && exp_rdy) acc++;
            step();
            cyc++;
        end
        i_s_valid = 1'b0;
        i_full    = 2'b00;
        chk("feed_count", 64'(acc), 64'(upto));
    endtask

    // From the cycle after the last accepted word: run, optionally see done at RUN cycle L.
    task automatic arm_and_run(input int L);
        int  k;
        int  g;
        bit  exp_done;
        int  exp_start;
        chk("start_low_at_last_en", 64'(o_start), 64'd0);
        step();
        chk("start_rise", 64'(o_start), 64'd1);
        k = 0;
        while (o_start === 1'b1 && k < 40) begin
            i_done = (k == L);
            step();
            i_done = 1'b0;
            k++;
        end
        g = 0;
        while (o_busy === 1'b1 && g < 40) begin
            step();
            g++;
        end
        exp_done  = (L <= int'(TO) - 1);
        exp_start = exp_done ? L + 1 : int'(TO);
        if (exp_done) exp_cnt = (exp_cnt + 1) % (1 << CW);
        chk("start_cycles", 64'(n_start), 64'(exp_start));
        chk("job_done_pulses", 64'(n_jd), 64'(exp_done));
        chk("timeout_pulses", 64'(n_to), 64'(!exp_done));
        chk("gap_cycles", 64'(n_gap), 64'(GAPC));
        chk("busy_idle", 64'(o_busy), 64'd0);
        chk("job_cnt", 64'(o_job_cnt), 64'(exp_cnt));
        chk("in1_count", 64'(q1.size()), 64'd2);
        chk("in2_count", 64'(q2.size()), 64'd2);
        for (int i = 0; i < 2; i++) begin
            chk("in1_data", (q1.size() > i) ? 64'(q1[i]) : 64'hDEAD, 64'(w[2 * i]));
            chk("in2_data", (q2.size() > i) ? 64'(q2[i]) : 64'hDEAD, 64'(w[2 * i + 1]));
        end
        occ0 = 0;
        occ1 = 0;
    endtask

    // Wait out GAP after an abort and confirm a quiet return to IDLE.
    task automatic after_abort();
        int g;
        g = 0;
        chk("abort_start_low", 64'(o_start), 64'd0);
        chk("abort_busy_gap", 64'(o_busy), 64'd1);
        while (o_busy === 1'b1 && g < 40) begin
            step();
            g++;
        end
        chk("abort_gap_len", 64'(g), 64'(GAPC));
        chk("abort_no_done", 64'(n_jd), 64'd0);
        chk("abort_no_timeout", 64'(n_to), 64'd0);
        chk("abort_cnt_kept", 64'(o_job_cnt), 64'(exp_cnt));
        occ0 = 0;
        occ1 = 0;
    endtask

    task automatic async_reset();
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_start", 64'(o_start), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_in1_en", 64'(o_in1_en), 64'd0);
        chk("rst_in2_en", 64'(o_in2_en), 64'd0);
        chk("rst_cnt", 64'(o_job_cnt), 64'd0);
        @(negedge i_clk);
        i_rst   = 1'b0;
        exp_cnt = 0;
        occ0    = 0;
        occ1    = 0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset with a word offered: everything quiet.
        i_rst = 1'b1; i_en = 1'b0; i_abort = 1'b0; i_s_valid = 1'b1;
        i_s_data = 32'hA5A5_A5A5; i_full = 2'b00; i_done = 1'b0;
        occ0 = 0; occ1 = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_ready", 64'(o_s_ready), 64'd0);
        chk("reset_outs", {o_in1, o_in2}, 64'd0);
        chk("reset_flags", 64'({o_in1_en, o_in2_en, o_start, o_busy, o_job_done, o_timeout}), 64'd0);
        chk("reset_cnt", 64'(o_job_cnt), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step();
        chk("idle_ready", 64'(o_s_ready), 64'd0);
        i_s_valid = 1'b0;

        // Nominal job, back-to-back words 1..4, done at RUN cycle 6.
        new_job();
        for (int i = 0; i < int'(WORDS); i++) w[i] = DW'(i + 1);
        feed(4, 1'b0, cyc);
        chk("b2b_cycles", 64'(cyc), 64'd4);
        arm_and_run(6);

        // Backpressure on row1 while word 2 is offered.
        new_job();
        feed(1, 1'b0, cyc);
        i_s_valid = 1'b1;
        i_s_data  = w[1];
        i_full    = 2'b10;
        repeat (3) begin
            #1;
            chk("bp_ready_low", 64'(o_s_ready), 64'd0);
            step();
            chk("bp_no_in2", 64'(q2.size()), 64'd0);
        end
        i_full = 2'b00;
        feed(4, 1'b0, cyc);
        arm_and_run(3);

        // Timeout: no done at all.
        new_job();
        feed(4, 1'b1, cyc);
        arm_and_run(1000);

        // Abort in LOAD after one word; the word offered with abort is refused.
        new_job();
        feed(1, 1'b0, cyc);
        i_abort   = 1'b1;
        i_s_valid = 1'b1;
        i_s_data  = w[1];
        #1;
        chk("abort_ready_low", 64'(o_s_ready), 64'd0);
        step();
        i_abort   = 1'b0;
        i_s_valid = 1'b0;
        chk("abort_no_in2", 64'(q2.size()), 64'd0);
        after_abort();

        // Abort in RUN.
        new_job();
        feed(4, 1'b1, cyc);
        step();
        chk("run_start", 64'(o_start), 64'd1);
        step();
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        after_abort();

        // Fresh job after the aborts.
        new_job();
        feed(4, 1'b1, cyc);
        arm_and_run(4);

        // Done on the last allowed RUN cycle: done wins over timeout.
        new_job();
        feed(4, 1'b1, cyc);
        arm_and_run(int'(TO) - 1);

        // Randomized jobs.
        repeat (8) begin
            new_job();
            feed(4, 1'b1, cyc);
            arm_and_run($urandom_range(0, 20));
        end

        // Async reset while a write strobe is in flight.
        new_job();
        feed(4, 1'b0, cyc);
        chk("last_en_seen", 64'(o_in2_en), 64'd1);
        async_reset();

        // Async reset in RUN.
        new_job();
        feed(4, 1'b0, cyc);
        step();
        chk("run_before_rst", 64'(o_start), 64'd1);
        async_reset();

        // Counter wrap: 2^CW completed jobs bring it back to zero.
        repeat (1 << CW) begin
            new_job();
            feed(4, 1'b1, cyc);
            arm_and_run($urandom_range(0, 10));
        end
        chk("cnt_wrap", 64'(o_job_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
